// File: rtl/stream_upsizer_if.sv
// Valid/ready bundle around the upsizer: a narrow beat stream in, a packed word stream out.
// The slave modport is the upsizer's view; the master modport is the view of whatever drives it.
interface stream_upsizer_if #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
);
  logic                   master_valid;
  logic [WIDTH-1:0]       master_data;
  logic                   master_last;
  logic                   master_ready;
  logic                   slave_valid;
  logic [WIDTH*RATIO-1:0] slave_data;
  logic [RATIO-1:0]       slave_keep;
  logic                   slave_last;
  logic                   slave_ready;

  modport slave (
    input  master_valid, master_data, master_last, slave_ready,
    output master_ready, slave_valid, slave_data, slave_keep, slave_last
  );

  modport master (
    output master_valid, master_data, master_last, slave_ready,
    input  master_ready, slave_valid, slave_data, slave_keep, slave_last
  );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO consecutive WIDTH-bit beats into one registered WIDTH*RATIO-bit word.
// master_last closes a word early so a packet never shares a word with the next one.
module stream_upsizer #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
) (
  input  logic             clk,
  input  logic             rst,
  stream_upsizer_if.slave  bus_io
);
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH*RATIO-1:0] data_q, data_d;
  logic [RATIO-1:0]       keep_q, keep_d;
  logic                   last_q, last_d;
  logic                   shake_m, shake_s;

  // Ready depends only on the output register and the sink, never on master_valid.
  assign bus_io.master_ready = ~rst & (~bus_io.slave_valid | bus_io.slave_ready);
  assign shake_m = bus_io.master_valid & bus_io.master_ready;
  assign shake_s = bus_io.slave_valid & bus_io.slave_ready;

  assign bus_io.slave_valid = (state_q == HOLD);
  assign bus_io.slave_data  = data_q;
  assign bus_io.slave_keep  = keep_q;
  assign bus_io.slave_last  = last_q;

  // NOTE: every next-state signal takes its current value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        if (shake_m) begin
          data_d[int'(cnt_q)*WIDTH +: WIDTH] = bus_io.master_data;
          keep_d[cnt_q] = 1'b1;
          if (cnt_q == CNT_MAX || bus_io.master_last) begin
            state_d = HOLD;
            last_d  = bus_io.master_last;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (shake_s) begin
          // The leaving word is wiped so the next word starts with zeroed lanes.
          state_d = FILL;
          cnt_d   = '0;
          data_d  = '0;
          keep_d  = '0;
          last_d  = 1'b0;
          if (shake_m) begin
            data_d[WIDTH-1:0] = bus_io.master_data;
            keep_d[0]         = 1'b1;
            if (bus_io.master_last) begin
              state_d = HOLD;
              last_d  = 1'b1;
            end else begin
              cnt_d = CW'(1);
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer: directed scenarios plus a randomized run,
// with a beat-grouping reference model and scoreboard kept alongside the stimulus.
module tb_stream_upsizer;
  localparam int W = 32;
  localparam int R = 4;

  typedef struct {
    logic [W*R-1:0] data;
    logic [R-1:0]   keep;
    logic           last;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_upsizer_if #(.WIDTH(W), .RATIO(R)) bus ();
  stream_upsizer #(.WIDTH(W), .RATIO(R)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  int n_cmp = 0;
  int n_err = 0;
  int n_words = 0;

  // Reference model: accepted beats are grouped into words by the packing rules.
  word_t          exp_q[$];
  logic [W-1:0]   acc[$];
  logic           prev_stall = 1'b0;
  logic [W*R-1:0] prev_data;
  logic [R-1:0]   prev_keep;
  logic           prev_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (bus.slave_valid !== 1'b1 || bus.slave_data !== prev_data ||
            bus.slave_keep !== prev_keep || bus.slave_last !== prev_last) begin
          n_err++;
          $display("FAIL stall_stable: got v=%0b d=%h k=%b l=%0b want v=1 d=%h k=%b l=%0b",
                   bus.slave_valid, bus.slave_data, bus.slave_keep, bus.slave_last,
                   prev_data, prev_keep, prev_last);
        end
      end
      if (bus.slave_valid && bus.slave_ready) begin
        n_words++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_word: got d=%h with no word expected", bus.slave_data);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          if (bus.slave_data !== e.data) begin
            n_err++;
            $display("FAIL sb_data: got %h want %h", bus.slave_data, e.data);
          end
          n_cmp++;
          if (bus.slave_keep !== e.keep) begin
            n_err++;
            $display("FAIL sb_keep: got %b want %b", bus.slave_keep, e.keep);
          end
          n_cmp++;
          if (bus.slave_last !== e.last) begin
            n_err++;
            $display("FAIL sb_last: got %0b want %0b", bus.slave_last, e.last);
          end
        end
      end
      if (bus.master_valid && bus.master_ready) begin
        acc.push_back(bus.master_data);
        if (acc.size() == R || bus.master_last) begin
          word_t w;
          w.data = '0;
          w.keep = '0;
          w.last = bus.master_last;
          for (int i = 0; i < acc.size(); i++) begin
            w.data[i*W +: W] = acc[i];
            w.keep[i] = 1'b1;
          end
          exp_q.push_back(w);
          acc.delete();
        end
      end
      prev_stall = bus.slave_valid & ~bus.slave_ready;
      prev_data  = bus.slave_data;
      prev_keep  = bus.slave_keep;
      prev_last  = bus.slave_last;
    end
  end

  task automatic set_in(input logic v, input logic [W-1:0] d, input logic l, input logic sr);
    bus.master_valid = v;
    bus.master_data  = d;
    bus.master_last  = l;
    bus.slave_ready  = sr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.slave_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", bus.slave_valid); end
    n_cmp++;
    if (bus.slave_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.slave_data); end
    n_cmp++;
    if (bus.slave_keep !== '0) begin n_err++; $display("FAIL reset_keep: got %b want 0", bus.slave_keep); end
    n_cmp++;
    if (bus.slave_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %0b want 0", bus.slave_last); end
    n_cmp++;
    if (bus.master_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b want 0", bus.master_ready); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.master_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %0b want 1", bus.master_ready); end
    next_cycle();
  endtask

  task automatic test_full_word();
    logic [W-1:0]   b[4];
    logic [W*R-1:0] exp_d;
    b[0] = 32'h11; b[1] = 32'h22; b[2] = 32'h33; b[3] = 32'h44;
    exp_d = {32'h44, 32'h33, 32'h22, 32'h11};
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, b[i], (i == 3), 1'b1);
      @(negedge clk);
      if (i == 3) begin
        n_cmp++;
        if (bus.slave_valid !== 1'b0) begin n_err++; $display("FAIL full_latency: got valid %0b want 0", bus.slave_valid); end
      end
      next_cycle();
    end
    set_in(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.slave_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %0b want 1", bus.slave_valid); end
    n_cmp++;
    if (bus.slave_data !== exp_d) begin n_err++; $display("FAIL full_data: got %h want %h", bus.slave_data, exp_d); end
    n_cmp++;
    if (bus.slave_keep !== 4'b1111) begin n_err++; $display("FAIL full_keep: got %b want 1111", bus.slave_keep); end
    n_cmp++;
    if (bus.slave_last !== 1'b1) begin n_err++; $display("FAIL full_last: got %0b want 1", bus.slave_last); end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.slave_valid !== 1'b0) begin n_err++; $display("FAIL full_drain: got valid %0b want 0", bus.slave_valid); end
    next_cycle();
  endtask

  task automatic test_partial();
    logic [W*R-1:0] exp_d;
    set_in(1'b1, 32'hA, 1'b0, 1'b1); next_cycle();
    set_in(1'b1, 32'hB, 1'b1, 1'b1); next_cycle();
    set_in(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    exp_d = {32'h0, 32'h0, 32'hB, 32'hA};
    n_cmp++;
    if (bus.slave_data !== exp_d) begin n_err++; $display("FAIL partial_data: got %h want %h", bus.slave_data, exp_d); end
    n_cmp++;
    if (bus.slave_keep !== 4'b0011) begin n_err++; $display("FAIL partial_keep: got %b want 0011", bus.slave_keep); end
    n_cmp++;
    if (bus.slave_last !== 1'b1) begin n_err++; $display("FAIL partial_last: got %0b want 1", bus.slave_last); end
    // Next packet must start in lane 0 of a fresh word.
    set_in(1'b1, 32'hC, 1'b0, 1'b1); next_cycle();
    set_in(1'b1, 32'hD, 1'b0, 1'b1); next_cycle();
    set_in(1'b1, 32'hE, 1'b0, 1'b1); next_cycle();
    set_in(1'b1, 32'hF, 1'b1, 1'b1); next_cycle();
    set_in(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    exp_d = {32'hF, 32'hE, 32'hD, 32'hC};
    n_cmp++;
    if (bus.slave_data !== exp_d) begin n_err++; $display("FAIL next_packet_data: got %h want %h", bus.slave_data, exp_d); end
    set_in(1'b0, '0, 1'b0, 1'b1);
    repeat (2) next_cycle();
  endtask

  task automatic test_stall();
    logic [W*R-1:0] exp_d;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, W'(i), 1'b0, 1'b0);
      next_cycle();
    end
    exp_d = {32'h4, 32'h3, 32'h2, 32'h1};
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h55, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (bus.master_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %0b want 0", i, bus.master_ready); end
      n_cmp++;
      if (bus.slave_valid !== 1'b1 || bus.slave_data !== exp_d) begin
        n_err++;
        $display("FAIL stall_word[%0d]: got v=%0b d=%h want v=1 d=%h", i, bus.slave_valid, bus.slave_data, exp_d);
      end
      next_cycle();
    end
    set_in(1'b1, 32'h55, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.master_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %0b want 1", bus.master_ready); end
    next_cycle();
    set_in(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    exp_d = {32'h0, 32'h0, 32'h0, 32'h55};
    n_cmp++;
    if (bus.slave_valid !== 1'b0 || bus.slave_data !== exp_d || bus.slave_keep !== 4'b0001) begin
      n_err++;
      $display("FAIL release_lane0: got v=%0b d=%h k=%b want v=0 d=%h k=0001",
               bus.slave_valid, bus.slave_data, bus.slave_keep, exp_d);
    end
    set_in(1'b1, 32'h66, 1'b0, 1'b1); next_cycle();
    set_in(1'b1, 32'h77, 1'b0, 1'b1); next_cycle();
    set_in(1'b1, 32'h88, 1'b1, 1'b1); next_cycle();
    set_in(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    exp_d = {32'h88, 32'h77, 32'h66, 32'h55};
    n_cmp++;
    if (bus.slave_data !== exp_d) begin n_err++; $display("FAIL release_word: got %h want %h", bus.slave_data, exp_d); end
    repeat (2) next_cycle();
  endtask

  task automatic test_back_to_back();
    int w0;
    int drops;
    w0 = n_words;
    drops = 0;
    for (int i = 0; i < 64; i++) begin
      set_in(1'b1, $urandom, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.master_ready !== 1'b1) drops++;
      next_cycle();
    end
    set_in(1'b0, '0, 1'b0, 1'b1);
    repeat (3) next_cycle();
    n_cmp++;
    if (drops != 0) begin n_err++; $display("FAIL b2b_ready_drops: got %0d want 0", drops); end
    n_cmp++;
    if (n_words - w0 != 16) begin n_err++; $display("FAIL b2b_word_count: got %0d want 16", n_words - w0); end
    n_cmp++;
    if (exp_q.size() != 0 || acc.size() != 0) begin
      n_err++;
      $display("FAIL b2b_leftover: got %0d words %0d beats pending want 0", exp_q.size(), acc.size());
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    logic [W*R-1:0] exp_d;
    w0 = n_words;
    set_in(1'b1, 32'h71, 1'b0, 1'b1); next_cycle();
    set_in(1'b1, 32'h72, 1'b0, 1'b1); next_cycle();
    set_in(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.slave_data !== '0 || bus.slave_keep !== '0 || bus.slave_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: got v=%0b d=%h k=%b want all 0", bus.slave_valid, bus.slave_data, bus.slave_keep);
    end
    n_cmp++;
    if (bus.master_ready !== 1'b0) begin n_err++; $display("FAIL midreset_ready: got %0b want 0", bus.master_ready); end
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, W'(32'h91 + i), 1'b0, 1'b1);
      next_cycle();
    end
    set_in(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    exp_d = {32'h94, 32'h93, 32'h92, 32'h91};
    n_cmp++;
    if (bus.slave_valid !== 1'b1 || bus.slave_data !== exp_d || bus.slave_keep !== 4'b1111) begin
      n_err++;
      $display("FAIL midreset_word: got v=%0b d=%h k=%b want v=1 d=%h k=1111",
               bus.slave_valid, bus.slave_data, bus.slave_keep, exp_d);
    end
    n_cmp++;
    if (n_words != w0) begin n_err++; $display("FAIL midreset_emitted: got %0d words want %0d", n_words, w0); end
    repeat (2) next_cycle();
  endtask

  task automatic test_random();
    bit done;
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) != 0));
      next_cycle();
    end
    // Close any open word with a last beat, then drain.
    done = 1'b0;
    set_in(1'b1, 32'hFEED, 1'b1, 1'b1);
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (bus.master_ready) done = 1'b1;
      next_cycle();
    end
    set_in(1'b0, '0, 1'b0, 1'b1);
    repeat (4) next_cycle();
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL rand_flush_accept: got no accept want accept within 10 cycles"); end
    n_cmp++;
    if (exp_q.size() != 0 || acc.size() != 0) begin
      n_err++;
      $display("FAIL rand_leftover: got %0d words %0d beats pending want 0", exp_q.size(), acc.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b1);
    test_reset();
    test_full_word();
    test_partial();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
